// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
// Segment patterns are active-high with bit0 = a through bit6 = g.
package seg7_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWELL = 2'd1,
      ST_BLANK = 2'd2
   } seg7_state_e;

   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   function automatic int seg7_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to segment decoder; only decimal digits light segments,
// values 10..15 show a blank digit.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   // Digit lookup
   always_comb begin
      o_seg = SEG_BLANK;
      case (i_nibble)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with dwell/blank timing, a one-deep
// load buffer committed only at frame boundaries, and leading-zero blanking.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 50000,
   parameter int BLANK_CYC  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    lz_suppress,
   input  logic                    load_valid,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   output logic                    load_ready,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic                    frame_done
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam int CW = $clog2(seg7_max(PRESCALE, BLANK_CYC) + 1);
   localparam logic [IW-1:0]         LAST_IDX   = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0]         DWELL_LAST = CW'(PRESCALE - 1);
   localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [NUM_DIGITS-1:0] ONE_HOT    = NUM_DIGITS'(1);
   localparam bit                    HAS_BLANK  = (BLANK_CYC > 0);

   seg7_state_e             r_state;
   logic [IW-1:0]           r_idx;
   logic [CW-1:0]           r_cnt;
   logic [4*NUM_DIGITS-1:0] r_active;
   logic [4*NUM_DIGITS-1:0] r_pending;
   logic                    r_pend_valid;
   logic [6:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_dig_en;
   logic                    r_frame_done;

   seg7_state_e             w_state_nxt;
   logic [IW-1:0]           w_idx_nxt;
   logic [IW-1:0]           w_idx_inc;
   logic [CW-1:0]           w_cnt_nxt;
   logic                    w_wrap;
   logic                    w_xfer;
   logic                    w_commit;
   logic [4*NUM_DIGITS-1:0] w_active_nxt;
   logic [3:0]              w_nibble;
   logic [6:0]              w_dec_seg;
   logic [6:0]              w_seg_nxt;
   logic [NUM_DIGITS-1:0]   w_dig_en_nxt;

   // True when every nibble from position idx upward is zero.
   function automatic logic upper_zero(input logic [4*NUM_DIGITS-1:0] v,
                                       input logic [IW-1:0] idx);
      logic z;
      z = 1'b1;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         z = z & ~((j >= int'(idx)) && (v[4*j +: 4] != 4'd0));
      end
      return z;
   endfunction

   assign w_idx_inc = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

   // Scan sequencing: dwell -> optional blank -> next digit, wrapping per frame
   always_comb begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
      w_wrap      = 1'b0;
      if (!enable) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_DWELL;
            end
            ST_DWELL: begin
               if (r_cnt != DWELL_LAST) begin
                  w_state_nxt = ST_DWELL;
                  w_idx_nxt   = r_idx;
                  w_cnt_nxt   = r_cnt + 1'b1;
               end else if (HAS_BLANK) begin
                  w_state_nxt = ST_BLANK;
                  w_idx_nxt   = r_idx;
               end else begin
                  w_state_nxt = ST_DWELL;
                  w_idx_nxt   = w_idx_inc;
                  w_wrap      = (r_idx == LAST_IDX);
               end
            end
            ST_BLANK: begin
               if (r_cnt != BLANK_LAST) begin
                  w_state_nxt = ST_BLANK;
                  w_idx_nxt   = r_idx;
                  w_cnt_nxt   = r_cnt + 1'b1;
               end else begin
                  w_state_nxt = ST_DWELL;
                  w_idx_nxt   = w_idx_inc;
                  w_wrap      = (r_idx == LAST_IDX);
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // A frame never mixes values: new data lands only while idle or at the wrap.
   assign w_xfer       = load_valid && !r_pend_valid;
   assign w_commit     = r_pend_valid && ((r_state == ST_IDLE) || w_wrap);
   assign w_active_nxt = w_commit ? r_pending : r_active;
   assign w_nibble     = w_active_nxt[{w_idx_nxt, 2'b00} +: 4];

   seg7_hex_decode u_dec (
      .i_nibble (w_nibble),
      .o_seg    (w_dec_seg)
   );

   // Output pattern for the upcoming cycle, including leading-zero blanking
   always_comb begin
      w_seg_nxt    = SEG_BLANK;
      w_dig_en_nxt = '0;
      if (w_state_nxt == ST_DWELL) begin
         w_dig_en_nxt = ONE_HOT << w_idx_nxt;
         if (lz_suppress && (w_idx_nxt != '0) && upper_zero(w_active_nxt, w_idx_nxt)) begin
            w_seg_nxt = SEG_BLANK;
         end else begin
            w_seg_nxt = w_dec_seg;
         end
      end else begin
         w_seg_nxt    = SEG_BLANK;
         w_dig_en_nxt = '0;
      end
   end

   // State, digit index and shared dwell/blank counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Pending/active display buffers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active     <= '0;
         r_pending    <= '0;
         r_pend_valid <= 1'b0;
      end else begin
         r_active <= w_active_nxt;
         if (w_xfer) begin
            r_pending    <= load_data;
            r_pend_valid <= 1'b1;
         end else if (w_commit) begin
            r_pend_valid <= 1'b0;
         end
      end
   end

   // Registered display drive
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg        <= SEG_BLANK;
         r_dig_en     <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_seg        <= w_seg_nxt;
         r_dig_en     <= w_dig_en_nxt;
         r_frame_done <= w_wrap;
      end
   end

   assign load_ready = !r_pend_valid;
   assign seg        = r_seg;
   assign dig_en     = r_dig_en;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: frame-position reference model plus
// directed literal checks, followed by randomized enable/load/lz traffic.
module tb_seg7_scan_ctrl;

   localparam int ND    = 4;
   localparam int PS    = 4;
   localparam int BC    = 1;
   localparam int SLOT  = PS + BC;
   localparam int FRAME = ND * SLOT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        lz_suppress = 1'b0;
   logic        load_valid = 1'b0;
   logic [15:0] load_data = 16'h0000;
   logic        load_ready;
   logic [6:0]  seg;
   logic [3:0]  dig_en;
   logic        frame_done;

   seg7_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE(PS), .BLANK_CYC(BC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .lz_suppress (lz_suppress),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .seg         (seg),
      .dig_en      (dig_en),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_on   = 1'b0;

   logic [6:0] seg_tab [0:15] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                  7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                  7'b1111111, 7'b1101111, 7'b0000000, 7'b0000000,
                                  7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

   // Reference: scanning time since enable, position within the frame, buffers
   bit          m_on;
   int          m_t;
   logic [15:0] m_act, m_pend;
   bit          m_pv;
   logic [6:0]  exp_seg;
   logic [3:0]  exp_dig;
   logic        exp_fd;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin : model
      bit          was_on, xfer, wrap, l_on, l_pv;
      int          l_t, p, d;
      logic [15:0] l_act, l_pend, nib;
      logic [6:0]  l_seg;
      logic [3:0]  l_dig;
      if (!rst_n) begin
         m_on <= 1'b0; m_t <= 0; m_act <= 16'h0; m_pend <= 16'h0; m_pv <= 1'b0;
         exp_seg <= 7'h0; exp_dig <= 4'h0; exp_fd <= 1'b0;
      end else begin
         l_on = m_on; l_t = m_t; l_act = m_act; l_pend = m_pend; l_pv = m_pv;
         was_on = l_on;
         xfer   = load_valid && !l_pv;
         wrap   = 1'b0;
         if (!enable) begin
            l_on = 1'b0; l_t = 0;
         end else if (!l_on) begin
            l_on = 1'b1; l_t = 0;
         end else begin
            l_t  = l_t + 1;
            wrap = (l_t % FRAME == 0);
         end
         if (l_pv && (!was_on || wrap)) begin
            l_act = l_pend; l_pv = 1'b0;
         end
         if (xfer) begin
            l_pend = load_data; l_pv = 1'b1;
         end
         l_seg = 7'h0; l_dig = 4'h0;
         if (l_on) begin
            p = l_t % FRAME;
            d = p / SLOT;
            if (p % SLOT < PS) begin
               l_dig = 4'(1 << d);
               nib   = l_act >> (4 * d);
               if (lz_suppress && d > 0 && nib == 16'h0) l_seg = 7'h0;
               else l_seg = seg_tab[nib[3:0]];
            end
         end
         m_on <= l_on; m_t <= l_t; m_act <= l_act; m_pend <= l_pend; m_pv <= l_pv;
         exp_seg <= l_seg; exp_dig <= l_dig; exp_fd <= wrap;
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         check("seg", 32'(seg), 32'(exp_seg));
         check("dig_en", 32'(dig_en), 32'(exp_dig));
         check("frame_done", 32'(frame_done), 32'(exp_fd));
         check("load_ready", 32'(load_ready), 32'(!m_pv));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [15:0] v);
      load_valid = 1'b1;
      load_data  = v;
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic wait_frame();
      int k = 0;
      while (frame_done !== 1'b1 && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (frame_done !== 1'b1) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_frame: frame_done not seen within 60 cycles at %0t", $time);
      end
   endtask

   initial begin
      logic [15:0] mask;
      repeat (3) @(negedge clk);
      cmp_on = 1'b1;
      check("rst_seg", 32'(seg), 32'h0);
      check("rst_dig", 32'(dig_en), 32'h0);
      check("rst_fd", 32'(frame_done), 32'h0);
      check("rst_ready", 32'(load_ready), 32'h1);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // basic scan of 0x1234
      load(16'h1234);
      check("idle_busy", 32'(load_ready), 32'h0);
      @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      check("c1_dig", 32'(dig_en), 32'h1);
      check("c1_seg", 32'(seg), 32'(7'b1100110));
      check("c1_fd", 32'(frame_done), 32'h0);
      step(3);
      check("c4_dig", 32'(dig_en), 32'h1);
      step(1);
      check("c5_blank", 32'({dig_en, seg}), 32'h0);
      step(1);
      check("c6_dig", 32'(dig_en), 32'h2);
      check("c6_seg", 32'(seg), 32'(7'b1001111));
      step(15);
      check("c21_fd", 32'(frame_done), 32'h1);
      check("c21_dig", 32'(dig_en), 32'h1);

      // leading-zero suppression on 0x0090
      lz_suppress = 1'b1;
      load(16'h0090);
      check("lz_busy", 32'(load_ready), 32'h0);
      wait_frame();
      check("lz_d0", 32'(seg), 32'(7'b0111111));
      step(5);
      check("lz_d1", 32'(seg), 32'(7'b1101111));
      step(5);
      check("lz_d2_dig", 32'(dig_en), 32'h4);
      check("lz_d2_seg", 32'(seg), 32'h0);
      step(5);
      check("lz_d3_dig", 32'(dig_en), 32'h8);
      check("lz_d3_seg", 32'(seg), 32'h0);

      // mid-frame load is deferred to the wrap; second offer is ignored
      lz_suppress = 1'b0;
      wait_frame();
      step(2);
      load(16'h5678);
      check("mid_busy", 32'(load_ready), 32'h0);
      check("mid_old_seg", 32'(seg), 32'(7'b0111111));
      load(16'h1111);
      step(1);
      check("mid_old_d1", 32'(seg), 32'(7'b1101111));
      wait_frame();
      check("wrap_seg", 32'(seg), 32'(7'b1111111));
      check("wrap_fd", 32'(frame_done), 32'h1);
      check("wrap_ready", 32'(load_ready), 32'h1);
      step(5);
      check("ignored_d1", 32'(seg), 32'(7'b0000111));

      // hex digit shows blank
      load(16'h000A);
      wait_frame();
      check("hexA_dig", 32'(dig_en), 32'h1);
      check("hexA_seg", 32'(seg), 32'h0);

      // disable mid-dwell and restart
      step(1);
      enable = 1'b0;
      @(negedge clk);
      check("dis_out", 32'({frame_done, dig_en, seg}), 32'h0);
      step(2);
      enable = 1'b1;
      @(negedge clk);
      check("re_c1_dig", 32'(dig_en), 32'h1);
      check("re_c1_fd", 32'(frame_done), 32'h0);
      step(3);
      check("re_c4_dig", 32'(dig_en), 32'h1);
      step(1);
      check("re_c5_dig", 32'(dig_en), 32'h0);

      // reset during blank with a pending load
      step(3);
      load(16'h4321);
      check("pre_rst_busy", 32'(load_ready), 32'h0);
      step(1);
      check("pre_rst_blank", 32'(dig_en), 32'h0);
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("in_rst_out", 32'({frame_done, dig_en, seg}), 32'h0);
      check("in_rst_ready", 32'(load_ready), 32'h1);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_dig", 32'(dig_en), 32'h1);
      check("post_rst_seg", 32'(seg), 32'(7'b0111111));

      // randomized traffic, model compare every cycle
      for (int i = 0; i < 4000; i++) begin
         enable      = ($urandom_range(0, 99) != 0);
         lz_suppress = ($urandom_range(0, 3) != 0);
         load_valid  = ($urandom_range(0, 7) == 0);
         for (int j = 0; j < 4; j++) mask[4*j +: 4] = ($urandom_range(0, 1) != 0) ? 4'hF : 4'h0;
         load_data = 16'($urandom) & mask;
         @(negedge clk);
      end
      load_valid = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
